mem_bus_master: RTL and testbench

Parametrised single-port memory bus master that sits between the CPU core and the RAM. It arbitrates an instruction-fetch channel and a data load/store channel onto one RAM port. It supports sub-word accesses with byte enables, sign/zero extension, RAM wait states, misalignment detection and a bus timeout. It replaces the fixed 64-bit, zero-wait, fetch-from-upper-half bus logic of the current core.

---
 rtl/mem_bus_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Single-port RAM bus master arbitrating instruction fetch and data load/store.
// Handles sub-word lanes, sign/zero extension, wait states, misalignment and bus timeout.
module mem_bus_master #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int ILEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [ILEN-1:0]     if_instr,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_size,
    input  logic                d_unsigned,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    output logic                d_gnt,
    output logic                d_valid,
    output logic [XLEN-1:0]     d_rdata,
    output logic                d_err,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_be,
    input  logic [XLEN-1:0]     bus_rdata,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_oe,
    input  logic                ram_ready
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int BE_W  = XLEN / 8;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              chan_q, chan_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        arb_q, arb_d;
    logic [ILEN-1:0]   if_instr_q, if_instr_d;
    logic              if_err_q, if_err_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    logic              sel_data;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [2:0]        mis_mask;
    logic              req_mis;
    logic [OFF_W-1:0]  offset;
    logic [OFF_W+2:0]  bit_sh;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   keep;
    logic [XLEN-1:0]   load_ext;
    logic              sign_bit;
    logic [7:0]        be_base;
    logic              in_access;

    // Data wins unless fetch has waited through two consecutive data grants.
    always_comb begin
        sel_data = d_req && !(if_req && arb_q == 2'd2);
        d_gnt    = (state_q == IDLE) && sel_data;
        if_gnt   = (state_q == IDLE) && if_req && !sel_data;
        req_addr = sel_data ? d_addr : if_addr;
        req_size = sel_data ? d_size : 2'd2;
        case (req_size)
            2'd0:    mis_mask = 3'b000;
            2'd1:    mis_mask = 3'b001;
            2'd2:    mis_mask = 3'b011;
            default: mis_mask = 3'b111;
        endcase
        req_mis = (|(req_addr[2:0] & mis_mask)) || (req_size == 2'd3 && XLEN == 32);
    end

    always_comb begin
        offset = addr_q[OFF_W-1:0];
        bit_sh = {offset, 3'b000};
        lane   = bus_rdata >> bit_sh;
        case (size_q)
            2'd0: begin
                keep     = XLEN'(8'hFF);
                sign_bit = lane[7];
                be_base  = 8'h01;
            end
            2'd1: begin
                keep     = XLEN'(16'hFFFF);
                sign_bit = lane[15];
                be_base  = 8'h03;
            end
            2'd2: begin
                keep     = XLEN'(32'hFFFF_FFFF);
                sign_bit = lane[31];
                be_base  = 8'h0F;
            end
            default: begin
                keep     = '1;
                sign_bit = 1'b0;
                be_base  = 8'hFF;
            end
        endcase
        load_ext = (lane & keep) | ((sign_bit && !uns_q) ? ~keep : '0);
    end

    // Bus and strobes derive only from registered state, so they are stable across ACCESS.
    always_comb begin
        in_access = (state_q == ACCESS);
        ram_cs    = in_access;
        ram_we    = in_access && we_q;
        ram_oe    = in_access && !we_q;
        bus_addr  = in_access ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
        bus_be    = in_access ? (BE_W'(be_base) << offset) : '0;
        bus_wdata = in_access ? (wdata_q << bit_sh) : '0;
        if_valid  = (state_q == RESP) && !chan_q;
        d_valid   = (state_q == RESP) && chan_q;
        if_instr  = if_instr_q;
        if_err    = if_err_q;
        d_rdata   = d_rdata_q;
        d_err     = d_err_q;
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        addr_d     = addr_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        timer_d    = timer_q;
        arb_d      = arb_q;
        if_instr_d = if_instr_q;
        if_err_d   = if_err_q;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;
        case (state_q)
            IDLE: begin
                if (d_gnt || if_gnt) begin
                    chan_d  = d_gnt;
                    addr_d  = req_addr;
                    we_d    = d_gnt && d_we;
                    size_d  = req_size;
                    uns_d   = !d_gnt || d_unsigned;
                    wdata_d = d_gnt ? d_wdata : '0;
                    timer_d = '0;
                    if (if_gnt || !if_req) begin
                        arb_d = 2'd0;
                    end else begin
                        arb_d = arb_q + 2'd1;
                    end
                    // Misaligned requests skip the bus entirely and report an error.
                    if (req_mis) begin
                        state_d = RESP;
                        if (d_gnt) begin
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            if_err_d   = 1'b1;
                            if_instr_d = '0;
                        end
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                timer_d = timer_q + 1'b1;
                if (ram_ready) begin
                    state_d = RESP;
                    if (chan_q) begin
                        d_err_d   = 1'b0;
                        d_rdata_d = we_q ? '0 : load_ext;
                    end else begin
                        if_err_d   = 1'b0;
                        if_instr_d = lane[ILEN-1:0];
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    if (chan_q) begin
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_err_d   = 1'b1;
                        if_instr_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            chan_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            timer_q    <= '0;
            arb_q      <= 2'd0;
            if_instr_q <= '0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wdata_q    <= wdata_d;
            timer_q    <= timer_d;
            arb_q      <= arb_d;
            if_instr_q <= if_instr_d;
            if_err_q   <= if_err_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master (XLEN=64): loads, stores, fairness, timeout,
// misalignment and asynchronous reset during an access.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_valid, if_err;
    logic [31:0] if_instr;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic        d_unsigned = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_gnt, d_valid, d_err;
    logic [63:0] d_rdata;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_be;
    logic [63:0] bus_rdata = '0;
    logic        ram_cs, ram_we, ram_oe;
    logic        ram_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    mem_bus_master #(.XLEN(64), .ADDR_W(64), .ILEN(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_valid    (d_valid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_oe     (ram_oe),
        .ram_ready  (ram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Runs one data request; ready rises after 'waits' ACCESS cycles; lat = cycles from gnt to d_valid.
    task automatic data_xfer(input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] rdata, input int waits,
                             output logic gnt0, output logic [7:0] be, output logic [63:0] baddr,
                             output logic [63:0] bwdata, output logic cs, output logic rwe,
                             output logic roe, output int lat, output logic [63:0] res,
                             output logic err);
        lat = -1;
        res = '0;
        err = 1'b0;
        tick();
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
        mid();
        gnt0 = d_gnt;
        tick();
        d_req = 1'b0; bus_rdata = rdata; ram_ready = (waits == 0);
        mid();
        be = bus_be; baddr = bus_addr; bwdata = bus_wdata; cs = ram_cs; rwe = ram_we; roe = ram_oe;
        for (int c = 1; c <= 40; c++) begin
            if (d_valid) begin
                lat = c;
                res = d_rdata;
                err = d_err;
                break;
            end
            tick();
            ram_ready = (c >= waits);
            mid();
        end
        ram_ready = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        mid();
        total++; if (bus_addr !== 64'h0) $display("[TB] FAIL reset_bus_addr: got %h expected 0", bus_addr); else passed++;
        total++; if ({bus_be, bus_wdata} !== 72'h0) $display("[TB] FAIL reset_bus_be_wdata: got %h/%h expected 0", bus_be, bus_wdata); else passed++;
        total++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b expected 000", {ram_cs, ram_we, ram_oe}); else passed++;
        total++; if ({if_gnt, d_gnt, if_valid, d_valid, if_err, d_err} !== 6'b0) $display("[TB] FAIL reset_ctrl: got %b expected 000000", {if_gnt, d_gnt, if_valid, d_valid, if_err, d_err}); else passed++;
        total++; if ({if_instr, d_rdata} !== 96'h0) $display("[TB] FAIL reset_data: got %h/%h expected 0", if_instr, d_rdata); else passed++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_double_load();
        logic g, cs, rwe, roe, err; logic [7:0] be; logic [63:0] ba, bw, res; int lat;
        data_xfer(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h8877665544332211, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (g !== 1'b1) $display("[TB] FAIL dload_gnt: got %b expected 1", g); else passed++;
        total++; if (be !== 8'hFF) $display("[TB] FAIL dload_be: got %h expected ff", be); else passed++;
        total++; if (ba !== 64'h10) $display("[TB] FAIL dload_addr: got %h expected 10", ba); else passed++;
        total++; if ({cs, rwe, roe} !== 3'b101) $display("[TB] FAIL dload_strobes: got %b expected 101", {cs, rwe, roe}); else passed++;
        total++; if (lat !== 2) $display("[TB] FAIL dload_latency: got %0d expected 2", lat); else passed++;
        total++; if (res !== 64'h8877665544332211) $display("[TB] FAIL dload_rdata: got %h expected 8877665544332211", res); else passed++;
        total++; if (err !== 1'b0) $display("[TB] FAIL dload_err: got %b expected 0", err); else passed++;
        tick();
        mid();
        total++; if ({d_valid, d_rdata} !== {1'b0, 64'h8877665544332211}) $display("[TB] FAIL dload_hold: got %b/%h expected 0/8877665544332211", d_valid, d_rdata); else passed++;
    endtask

    task automatic test_byte_load();
        logic g, cs, rwe, roe, err; logic [7:0] be; logic [63:0] ba, bw, res; int lat;
        data_xfer(1'b0, 2'd0, 1'b0, 64'h5, 64'h0, 64'h112280FF_FFFFFFFF, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (be !== 8'h20) $display("[TB] FAIL byte_be: got %h expected 20", be); else passed++;
        total++; if (ba !== 64'h0) $display("[TB] FAIL byte_addr: got %h expected 0", ba); else passed++;
        total++; if (res !== 64'hFFFFFFFF_FFFFFF80) $display("[TB] FAIL byte_signed: got %h expected ffffffffffffff80", res); else passed++;
        data_xfer(1'b0, 2'd0, 1'b1, 64'h5, 64'h0, 64'h112280FF_FFFFFFFF, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (res !== 64'h80) $display("[TB] FAIL byte_unsigned: got %h expected 80", res); else passed++;
        data_xfer(1'b0, 2'd1, 1'b0, 64'h6, 64'h0, 64'h7FFE0000_00000000, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if ({be, res} !== {8'hC0, 64'h7FFE}) $display("[TB] FAIL half_positive: got %h/%h expected c0/7ffe", be, res); else passed++;
    endtask

    task automatic test_half_store();
        logic g, cs, rwe, roe, err; logic [7:0] be; logic [63:0] ba, bw, res; int lat;
        data_xfer(1'b1, 2'd1, 1'b0, 64'h22, 64'hBEEF, 64'hDEADBEEF_CAFEF00D, 2, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (ba !== 64'h20) $display("[TB] FAIL store_addr: got %h expected 20", ba); else passed++;
        total++; if (be !== 8'h0C) $display("[TB] FAIL store_be: got %h expected 0c", be); else passed++;
        total++; if (bw !== 64'h00000000_BEEF0000) $display("[TB] FAIL store_wdata: got %h expected beef0000", bw); else passed++;
        total++; if ({cs, rwe, roe} !== 3'b110) $display("[TB] FAIL store_strobes: got %b expected 110", {cs, rwe, roe}); else passed++;
        total++; if (lat !== 4) $display("[TB] FAIL store_latency: got %0d expected 4", lat); else passed++;
        total++; if ({res, err} !== 65'h0) $display("[TB] FAIL store_result: got %h/%b expected 0/0", res, err); else passed++;
    endtask

    task automatic test_fairness();
        int dcnt = 0;
        int ng = 0;
        int both = 0;
        string order = "";
        for (int c = 0; c < 80 && ng < 6; c++) begin
            tick();
            d_req = (dcnt < 4); d_we = 1'b0; d_size = 2'd3; d_unsigned = 1'b0; d_addr = 64'h40;
            if_req = 1'b1; if_addr = 64'h104;
            ram_ready = 1'b1; bus_rdata = 64'hA1B2C3D4_00000000;
            mid();
            if (d_gnt && if_gnt) both++;
            if (d_gnt) begin
                order = {order, "D"};
                dcnt++;
                ng++;
            end else if (if_gnt) begin
                order = {order, "F"};
                ng++;
            end
        end
        tick();
        d_req = 1'b0; if_req = 1'b0;
        repeat (3) tick();
        mid();
        ram_ready = 1'b0;
        total++; if (order != "DDFDDF") $display("[TB] FAIL fair_order: got %s expected DDFDDF", order); else passed++;
        total++; if (both !== 0) $display("[TB] FAIL fair_one_gnt: got %0d double grants expected 0", both); else passed++;
        total++; if ({if_instr, if_err} !== {32'hA1B2C3D4, 1'b0}) $display("[TB] FAIL fetch_instr: got %h/%b expected a1b2c3d4/0", if_instr, if_err); else passed++;
        total++; if (d_rdata !== 64'hA1B2C3D4_00000000) $display("[TB] FAIL fair_drdata_hold: got %h expected a1b2c3d400000000", d_rdata); else passed++;
    endtask

    task automatic test_timeout_misalign();
        logic g, cs, rwe, roe, err; logic [7:0] be; logic [63:0] ba, bw, res; int lat;
        data_xfer(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h5555, 100, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (lat !== 17) $display("[TB] FAIL timeout_latency: got %0d expected 17", lat); else passed++;
        total++; if ({err, res} !== {1'b1, 64'h0}) $display("[TB] FAIL timeout_result: got %b/%h expected 1/0", err, res); else passed++;
        data_xfer(1'b0, 2'd1, 1'b0, 64'h3, 64'h0, 64'h0, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if (g !== 1'b1) $display("[TB] FAIL misalign_gnt: got %b expected 1", g); else passed++;
        total++; if (lat !== 1) $display("[TB] FAIL misalign_latency: got %0d expected 1", lat); else passed++;
        total++; if ({cs, err, res} !== {1'b0, 1'b1, 64'h0}) $display("[TB] FAIL misalign_result: got cs=%b err=%b rdata=%h expected 0/1/0", cs, err, res); else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic g, cs, rwe, roe, err; logic [7:0] be; logic [63:0] ba, bw, res; int lat;
        int seen = 0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 64'h80; d_wdata = 64'h12345678; ram_ready = 1'b0;
        mid();
        tick();
        d_req = 1'b0;
        tick();
        mid();
        total++; if ({ram_cs, ram_we} !== 2'b11) $display("[TB] FAIL rst_pre_strobes: got %b expected 11", {ram_cs, ram_we}); else passed++;
        #1 reset = 1'b1;
        #1;
        total++; if ({ram_cs, ram_we, ram_oe, bus_be} !== 11'h0) $display("[TB] FAIL rst_async_drop: got %b/%h expected 000/00", {ram_cs, ram_we, ram_oe}, bus_be); else passed++;
        d_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            mid();
            if (d_valid) seen++;
            tick();
        end
        total++; if (seen !== 0) $display("[TB] FAIL rst_no_valid: got %0d valids expected 0", seen); else passed++;
        data_xfer(1'b0, 2'd2, 1'b0, 64'h88, 64'h0, 64'h00000000_80000001, 0, g, be, ba, bw, cs, rwe, roe, lat, res, err);
        total++; if ({lat, res, err} !== {32'd2, 64'hFFFFFFFF_80000001, 1'b0}) $display("[TB] FAIL rst_recover: got lat=%0d rdata=%h err=%b expected 2/ffffffff80000001/0", lat, res, err); else passed++;
    endtask

    initial begin
        test_reset();
        test_double_load();
        test_byte_load();
        test_half_store();
        test_fairness();
        test_timeout_misalign();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
